// File: rtl/updown_counter_param.sv
// updown_counter_param
// N-bit synchronous up/down counter with enable, parallel load, a runtime
// inclusive upper limit, wrap/saturate policy, a one-cycle wrap pulse, a
// sticky clip flag and combinational boundary status.
module updown_counter_param #(
    parameter int          WIDTH       = 8,
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] limit,
    input  logic             sat,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             clip_sticky,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH-1:0] RST_V = RESET_VALUE[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             clip_q, clip_d;
    logic             clip_set;

    // Next-state: load beats enable; an out-of-range count is pulled back to
    // the limit on any enabled step before the direction is even considered,
    // so nothing outside 0..limit is ever registered.
    always_comb begin
        count_d  = count_q;
        wrap_d   = 1'b0;
        clip_set = 1'b0;
        if (load) begin
            count_d = (load_value > limit) ? limit : load_value;
        end else if (enable) begin
            if (count_q > limit) begin
                count_d = limit;
            end else if (mode) begin
                if (count_q == limit) begin
                    if (sat) begin
                        clip_set = 1'b1;
                    end else begin
                        count_d = '0;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q + ONE;
                end
            end else begin
                if (count_q == '0) begin
                    if (sat) begin
                        clip_set = 1'b1;
                    end else begin
                        count_d = limit;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q - ONE;
                end
            end
        end
    end

    // Sticky clip: load clears, a new clip beats a simultaneous clr_flags.
    always_comb begin
        clip_d = clip_q;
        if (load)           clip_d = 1'b0;
        else if (clip_set)  clip_d = 1'b1;
        else if (clr_flags) clip_d = 1'b0;
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= RST_V;
            wrap_q  <= 1'b0;
            clip_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            clip_q  <= clip_d;
        end
    end

    assign count       = count_q;
    assign wrap        = wrap_q;
    assign clip_sticky = clip_q;
    assign at_max      = (count_q == limit);
    assign at_min      = (count_q == '0);

endmodule

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
- Parametrised N-bit synchronous up/down counter. Successor to the fixed 5-bit up/down counter.
- Adds count enable, parallel load, a runtime upper limit (modulus), wrap/saturate selection, a wrap-event pulse, a sticky clip flag and boundary status outputs.
- Used as a general-purpose event/position counter in lab designs and as the timebase for later DSD exercises.

Parameters:
- WIDTH, 8, counter width in bits (legal 2..32).
- RESET_VALUE, 0, value loaded into count on reset (must be <= 2**WIDTH-1).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- enable  input  1  count step enable; ignored when load=1
- mode  input  1  direction: 1 = up, 0 = down
- load  input  1  synchronous parallel load
- load_value  input  WIDTH  value to load
- limit  input  WIDTH  inclusive upper bound; count range is 0..limit
- sat  input  1  boundary policy: 1 = saturate, 0 = wrap
- clr_flags  input  1  synchronous clear of clip_sticky
- count  output  WIDTH  registered count value
- wrap  output  1  registered one-cycle pulse marking a wrap event
- clip_sticky  output  1  registered; set when a step is blocked by saturation
- at_max  output  1  combinational: count == limit
- at_min  output  1  combinational: count == 0

Behaviour:
- One clock; reset is asynchronous and active-high. Ports are named clk and reset.
- Reset asserted: count = RESET_VALUE, wrap = 0, clip_sticky = 0, held for as long as reset is high. Reset mid-operation aborts any step or load immediately.
- Per rising edge, priority is reset > load > enable. No enable means hold; wrap goes to 0.
- Load:
  - count <= min(load_value, limit); wrap <= 0; clip_sticky <= 0.
  - Load overrides enable, clr_flags and direction.
- Enabled up step (mode=1):
  - count < limit: count+1, wrap <= 0.
  - count == limit with sat=0: count <= 0, wrap <= 1.
  - count == limit with sat=1: count held, wrap <= 0, clip_sticky <= 1.
- Enabled down step (mode=0):
  - count > 0 and count <= limit: count-1, wrap <= 0.
  - count == 0 with sat=0: count <= limit, wrap <= 1.
  - count == 0 with sat=1: count held, clip_sticky <= 1.
- Out-of-range: if limit is lowered at runtime below the current count, any enabled step (either direction, either policy) forces count <= limit, wrap <= 0, with no clip. Non-enabled cycles leave count untouched.
- limit == 0: up or down with sat=0 gives count stays 0 and wrap pulses every enabled cycle. With sat=1, count stays 0 and clip is set.
- wrap is high for exactly the cycle in which the wrapped count value is first visible. Consecutive wraps give wrap high on consecutive cycles.
- clip_sticky:
  - Once set, stays set until clr_flags, load or reset.
  - If clr_flags and a new clip occur in the same cycle, set wins (clip_sticky = 1).
- mode and sat may change on any cycle; they take effect at the next edge. No pipeline; latency from inputs to count is one clock.
- Arithmetic is modulo 2**WIDTH internally, but no result outside 0..limit is ever registered.
- at_max and at_min are pure functions of the registered count and the limit input. Both are high when limit == 0 and count == 0.

Test Plan:
- WIDTH=5, reset high 10 ns then low, mode=0, enable=1, limit=31, sat=0 -> count 0 then 31 with wrap=1, then 30, 29, ...; mode=1 at 60 ns -> count increments by 1 per clock.
- limit=9, sat=0, mode=1, enable=1 from count=0 -> sequence 0..9, 0 with wrap=1 only on the cycle count returns to 0; at_max high while count=9.
- limit=9, sat=1, mode=1 -> count sticks at 9, clip_sticky rises the cycle after first blocked step; pulse clr_flags -> clip_sticky 0; next blocked step sets it again.
- load=1, load_value=20, limit=15 -> count=15. Then load=1 with enable=1, mode=0 -> load wins, count=load_value; clip_sticky cleared.
- count=12, limit changed to 5, enable=1, mode=0 -> next count 5, wrap=0, clip_sticky unchanged; with enable=0, count stays 12.
- Assert reset asynchronously mid-cycle while count=7 -> count=RESET_VALUE immediately (before next edge), wrap=0, clip_sticky=0; release -> counting resumes from RESET_VALUE.
